// File: rtl/alu_pkg.sv
// Shared opcode encoding for the RV32I integer ALU.
// The decoder and the benches use these constants so the encoding lives in one place.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SLL  = 4'b0101;
  localparam alu_op_t ALU_SRL  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_SLT  = 4'b1000;
  localparam alu_op_t ALU_SLTU = 4'b1001;

  // SUB, SLT and SLTU all run through the adder in subtract mode.
  function automatic logic op_uses_sub(input alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

  function automatic logic op_is_right_shift(input alu_op_t op);
    return (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift stages by bit-reversing the operand in and out.
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             shift_right,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0]          a_rev;
  logic [WIDTH-1:0]          out_rev;
  logic [SHW:0][WIDTH-1:0]   stage;
  logic                      fill;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign a_rev[i]   = a[WIDTH-1-i];
    assign out_rev[i] = stage[SHW][WIDTH-1-i];
  end

  // Sign fill only makes sense for an arithmetic right shift.
  assign fill     = arith & shift_right & a[WIDTH-1];
  assign stage[0] = shift_right ? a : a_rev;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int STEP = 1 << s;
    assign stage[s+1] = shamt[s] ? {{STEP{fill}}, stage[s][WIDTH-1:STEP]} : stage[s];
  end

  assign shifted = shift_right ? stage[SHW] : out_rev;

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: ten operations plus a zero flag, optionally registered
// so the block can sit on a pipeline boundary.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  logic             use_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] comb_result;
  logic             comb_zero;

  // One adder serves ADD, SUB and both compares: a + ~b + 1 in subtract mode.
  assign use_sub = op_uses_sub(alu_op);
  assign b_opnd  = use_sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, use_sub};
  assign sum     = sum_ext[WIDTH-1:0];
  assign carry   = sum_ext[WIDTH];

  // Signed less-than is the difference sign, flipped when the subtraction overflowed.
  assign overflow    = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign lt_signed   = sum[WIDTH-1] ^ overflow;
  assign lt_unsigned = ~carry;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .a           (a),
    .shamt       (b[SHW-1:0]),
    .shift_right (op_is_right_shift(alu_op)),
    .arith       (alu_op == ALU_SRA),
    .shifted     (shifted)
  );

  always_comb begin
    comb_result = '0;
    case (alu_op)
      ALU_ADD,
      ALU_SUB:  comb_result = sum;
      ALU_AND:  comb_result = a & b;
      ALU_OR:   comb_result = a | b;
      ALU_XOR:  comb_result = a ^ b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  comb_result = shifted;
      ALU_SLT:  comb_result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: comb_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default:  comb_result = '0;
    endcase
  end

  assign comb_zero = ~|comb_result;

  if (REG_OUT) begin : g_reg
    // Zero is captured alongside result so both leave the register together.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        result <= '0;
        zero   <= 1'b1;
      end else begin
        result <= comb_result;
        zero   <= comb_zero;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign result         = comb_result;
    assign zero           = comb_zero;
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: a combinational and a registered instance share the same stimulus
// and are compared against a plain-arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  alu_op_t       alu_op;
  logic [W-1:0]  res_c;
  logic          zero_c;
  logic [W-1:0]  res_r;
  logic          zero_r;

  int n_cmp;
  int n_fail;

  logic [W-1:0] exp_q[$];

  typedef struct packed {
    alu_op_t      op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
  } vec_t;

  alu #(.WIDTH(W), .REG_OUT(1'b0)) dut_comb (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .alu_op (alu_op),
    .result (res_c),
    .zero   (zero_c)
  );

  alu #(.WIDTH(W), .REG_OUT(1'b1)) dut_reg (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .alu_op (alu_op),
    .result (res_r),
    .zero   (zero_r)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_alu(input alu_op_t op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    int unsigned  sh;
    logic [W-1:0] r;
    sh = y % 32;
    case (op)
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_SLL:  r = x << sh;
      ALU_SRL:  r = x >> sh;
      ALU_SRA:  r = $signed(x) >>> sh;
      ALU_SLT:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      ALU_SLTU: r = (x < y) ? 1 : 0;
      default:  r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input alu_op_t op, input logic [W-1:0] x, input logic [W-1:0] y);
    alu_op = op;
    a      = x;
    b      = y;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (res_r !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected %h", res_r, 32'h0);
    end
    n_cmp++;
    if (zero_r !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_zero: got %b expected 1", zero_r);
    end
    // combinational instance ignores reset
    n_cmp++;
    if (res_c !== 32'd30) begin
      n_fail++;
      $display("FAIL comb_during_reset: got %h expected %h", res_c, 32'd30);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t vecs[23];
    vecs = '{
      '{ALU_ADD,  32'd10,        32'd20,        32'd30},
      '{ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0},
      '{ALU_SUB,  32'd50,        32'd30,        32'd20},
      '{ALU_SUB,  32'd10,        32'd10,        32'd0},
      '{ALU_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF},
      '{ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00},
      '{ALU_OR,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F},
      '{ALU_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F},
      '{ALU_SLL,  32'd1,         32'd4,         32'h0000_0010},
      '{ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000},
      '{ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000},
      '{ALU_SLL,  32'd1,         32'h24,        32'h0000_0010},
      '{ALU_SLL,  32'd1,         32'd31,        32'h8000_0000},
      '{ALU_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001},
      '{ALU_SRA,  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{ALU_SRA,  32'h4000_0000, 32'd30,        32'h0000_0001},
      '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1},
      '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0},
      '{ALU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0},
      '{ALU_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1},
      '{ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1},
      '{ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'd0},
      '{4'b1111,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0}
    };
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].x, vecs[i].y);
      #1;
      n_cmp++;
      if (res_c !== vecs[i].res || zero_c !== (vecs[i].res == 0)) begin
        n_fail++;
        $display("FAIL directed_comb[%0d] op=%b: got %h/%b expected %h/%b", i, vecs[i].op,
                 res_c, zero_c, vecs[i].res, (vecs[i].res == 0));
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (res_r !== vecs[i].res || zero_r !== (vecs[i].res == 0)) begin
        n_fail++;
        $display("FAIL directed_reg[%0d] op=%b: got %h/%b expected %h/%b", i, vecs[i].op,
                 res_r, zero_r, vecs[i].res, (vecs[i].res == 0));
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(alu_op_t'($urandom_range(0, 15)), pick_operand(), pick_operand());
      #1;
      exp = ref_alu(alu_op, a, b);
      n_cmp++;
      if (res_c !== exp || zero_c !== (exp == 0)) begin
        n_fail++;
        $display("FAIL random_comb op=%b a=%h b=%h: got %h/%b expected %h/%b", alu_op, a, b,
                 res_c, zero_c, exp, (exp == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(alu_op_t'($urandom_range(0, 15)), pick_operand(), pick_operand());
      exp_q.push_back(ref_alu(alu_op, a, b));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (res_r !== exp || zero_r !== (exp == 0)) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h/%b expected %h/%b", i, res_r, zero_r,
                 exp, (exp == 0));
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(ALU_OR, 32'h1234_5678, 32'h0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (res_r !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL preload: got %h expected %h", res_r, 32'h1234_5678);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (res_r !== '0 || zero_r !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%b expected %h/1", res_r, zero_r, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(ALU_ADD, 32'd10, 32'd20);
    #1;
    n_cmp++;
    if (res_r !== '0 || zero_r !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_until_edge: got %h/%b expected %h/1", res_r, zero_r, 32'h0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (res_r !== 32'd30 || zero_r !== 1'b0) begin
      n_fail++;
      $display("FAIL first_capture: got %h/%b expected %h/0", res_r, zero_r, 32'd30);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(ALU_ADD, 32'd10, 32'd20);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
